// File: rtl/if_fetch_queue_pkg.sv
// Shared memory-port encodings, fetch FSM states and the JAL immediate helper.
// Used by if_fetch_queue and the memory controller.
package if_fetch_queue_pkg;

    localparam logic [1:0] MEM_NOP  = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_SAVE = 2'b10;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam logic [31:0] ZeroWord = 32'h0;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_DRAIN = 2'b10
    } fetch_state_e;

    // Sign-extended J-type immediate of a JAL instruction word.
    function automatic logic [31:0] jal_imm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundle of the fetch-side memory port (IF_*) and the decode-side valid/ready port.
// master = fetch queue, slave = memory controller plus decode.
interface if_fetch_queue_if;

    logic [1:0]  IF_op;
    logic [1:0]  IF_len;
    logic [31:0] IF_addr;
    logic        IF_rdy;
    logic [31:0] IF_out;

    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_ready_in;

    modport master (
        output IF_op, IF_len, IF_addr,
        input  IF_rdy, IF_out,
        output inst_valid_out, inst_out, inst_pc_out,
        input  inst_ready_in
    );

    modport slave (
        input  IF_op, IF_len, IF_addr,
        output IF_rdy, IF_out,
        input  inst_valid_out, inst_out, inst_pc_out,
        output inst_ready_in
    );

endinterface

// File: rtl/if_fetch_queue_inst_fifo.sv
// DEPTH-entry FIFO of {instruction, pc} pairs with synchronous clear.
// Clear dominates push and pop; storage itself is not reset.
module if_inst_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC, one-outstanding-load FSM toward the memory controller and an
// instruction FIFO toward decode. Optional JAL target prediction: FETCH_JAL_PREDICT_EN.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic [31:0]             flush_pc_in,
    if_fetch_queue_if.master        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   if_addr_q, if_addr_d;
    logic [1:0]    if_op_q, if_op_d;
    logic [31:0]   pc_seq;
    logic          push, pop, clear, full, inst_valid;
    logic [63:0]   head;
    logic [CW-1:0] fifo_count;

`ifdef FETCH_JAL_PREDICT_EN
    assign pc_seq = (bus.IF_out[6:0] == OPCODE_JAL) ? if_addr_q + jal_imm(bus.IF_out)
                                                     : pc_q + 32'd4;
`else
    assign pc_seq = pc_q + 32'd4;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_op_d   = if_op_q;
        if_addr_d = if_addr_q;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        if (rdy_in) begin
            pop = inst_valid && bus.inst_ready_in && !flush_in;
            if (flush_in) begin
                clear = 1'b1;
                pc_d  = flush_pc_in;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!flush_in && !full) begin
                        if_op_d   = MEM_LOAD;
                        if_addr_d = pc_q;
                        state_d   = S_REQ;
                    end
                end
                S_REQ: begin
                    // A flush racing the return drops the word without a drain phase.
                    if (bus.IF_rdy) begin
                        if_op_d = MEM_NOP;
                        state_d = S_IDLE;
                        if (!flush_in) begin
                            push = 1'b1;
                            pc_d = pc_seq;
                        end
                    end else if (flush_in) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.IF_rdy) begin
                        if_op_d = MEM_NOP;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            if_op_q   <= MEM_NOP;
            if_addr_q <= ZeroWord;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            if_op_q   <= if_op_d;
            if_addr_q <= if_addr_d;
        end
    end

    if_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata ({bus.IF_out, if_addr_q}),
        .rdata (head),
        .count (fifo_count),
        .full  (full)
    );

    assign inst_valid         = (fifo_count != '0);
    assign bus.IF_op          = if_op_q;
    assign bus.IF_len         = MEM_WORD;
    assign bus.IF_addr        = if_addr_q;
    assign bus.inst_valid_out = inst_valid;
    assign bus.inst_out       = inst_valid ? head[63:32] : ZeroWord;
    assign bus.inst_pc_out    = inst_valid ? head[31:0]  : ZeroWord;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, in-order fetch, full FIFO, flush/drain
// corners and rdy_in freeze.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [31:0] flush_pc_in;

    int n_assert;
    int n_fail;

    if_fetch_queue_if bus();

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .flush_pc_in (flush_pc_in),
        .bus         (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int          lat;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0100006F : {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where a load is visible (bounded).
    task automatic wait_load(input string name);
        int i;
        i = 0;
        while (bus.IF_op !== MEM_LOAD && i < 50) begin
            @(negedge clk_in);
            i++;
        end
        check({name, "_issue"}, {30'd0, bus.IF_op}, {30'd0, MEM_LOAD});
    endtask

    // Wait for a load, check its address, return the word after lat cycles.
    task automatic serve(input string name, input int lat, input logic [31:0] exp_addr);
        wait_load(name);
        check({name, "_addr"}, bus.IF_addr, exp_addr);
        repeat (lat - 1) @(negedge clk_in);
        bus.IF_rdy = 1'b1;
        bus.IF_out = word_at(bus.IF_addr);
        @(negedge clk_in);
        bus.IF_rdy = 1'b0;
        check({name, "_nop"}, {30'd0, bus.IF_op}, {30'd0, MEM_NOP});
    endtask

    initial begin
        bit held;
        n_assert = 0;
        n_fail   = 0;

        vecs[0] = '{lat: 5, addr: 32'h0};
`ifdef FETCH_JAL_PREDICT_EN
        vecs[1] = '{lat: 5, addr: 32'h10};
        vecs[2] = '{lat: 5, addr: 32'h14};
`else
        vecs[1] = '{lat: 5, addr: 32'h4};
        vecs[2] = '{lat: 5, addr: 32'h8};
`endif

        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        flush_in          = 1'b0;
        flush_pc_in       = 32'h0;
        bus.IF_rdy        = 1'b0;
        bus.IF_out        = 32'h0;
        bus.inst_ready_in = 1'b1;

        // Reset state
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_op",    {30'd0, bus.IF_op},  {30'd0, MEM_NOP});
        check("rst_len",   {30'd0, bus.IF_len}, {30'd0, MEM_WORD});
        check("rst_addr",  bus.IF_addr, 32'h0);
        check("rst_valid", {31'd0, bus.inst_valid_out}, 32'd0);
        check("rst_inst",  bus.inst_out, 32'h0);
        check("rst_pc",    bus.inst_pc_out, 32'h0);
        rst_in = 1'b1;

        // In-order fetch after reset, one word at a time
        for (int k = 0; k < 3; k++) begin
            serve("t1", vecs[k].lat, vecs[k].addr);
            check("t1_valid", {31'd0, bus.inst_valid_out}, 32'd1);
            check("t1_hpc",   bus.inst_pc_out, vecs[k].addr);
            check("t1_hdata", bus.inst_out, word_at(vecs[k].addr));
        end

        // Fill the FIFO with decode stalled
        flush_in          = 1'b1;
        flush_pc_in       = 32'h40;
        bus.inst_ready_in = 1'b0;
        @(negedge clk_in);
        flush_in = 1'b0;
        check("t2_empty", {31'd0, bus.inst_valid_out}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            serve("t2", 2, 32'h40 + 32'(4 * k));
        end
        held = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            if (bus.IF_op !== MEM_NOP) held = 1'b0;
        end
        check("t2_full_noissue", {31'd0, held}, 32'd1);
        check("t2_head_pc",   bus.inst_pc_out, 32'h40);
        check("t2_head_data", bus.inst_out, word_at(32'h40));
        bus.inst_ready_in = 1'b1;
        @(negedge clk_in);
        bus.inst_ready_in = 1'b0;
        check("t2_pop_pc", bus.inst_pc_out, 32'h44);
        serve("t2_refill", 1, 32'h50);

        // Flush during a request: drain and discard
        flush_in          = 1'b1;
        flush_pc_in       = 32'h8;
        bus.inst_ready_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        check("t3_cleared", {31'd0, bus.inst_valid_out}, 32'd0);
        wait_load("t3");
        check("t3_addr", bus.IF_addr, 32'h8);
        flush_in    = 1'b1;
        flush_pc_in = 32'h100;
        @(negedge clk_in);
        flush_in = 1'b0;
        check("t3_drain_op", {30'd0, bus.IF_op}, {30'd0, MEM_LOAD});
        check("t3_drain_empty", {31'd0, bus.inst_valid_out}, 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        bus.IF_rdy = 1'b1;
        bus.IF_out = word_at(32'h8);
        @(negedge clk_in);
        bus.IF_rdy = 1'b0;
        check("t3_post_op", {30'd0, bus.IF_op}, {30'd0, MEM_NOP});
        check("t3_discard", {31'd0, bus.inst_valid_out}, 32'd0);
        bus.inst_ready_in = 1'b0;
        serve("t3_redirect", 1, 32'h100);
        check("t3_new_pc", bus.inst_pc_out, 32'h100);

        // Flush coinciding with IF_rdy and a dequeue
        wait_load("t4");
        check("t4_addr", bus.IF_addr, 32'h104);
        bus.IF_rdy        = 1'b1;
        bus.IF_out        = word_at(32'h104);
        flush_in          = 1'b1;
        flush_pc_in       = 32'h200;
        bus.inst_ready_in = 1'b1;
        @(negedge clk_in);
        bus.IF_rdy = 1'b0;
        flush_in   = 1'b0;
        check("t4_empty", {31'd0, bus.inst_valid_out}, 32'd0);
        check("t4_no_drain", {30'd0, bus.IF_op}, {30'd0, MEM_NOP});
        wait_load("t4_next");
        check("t4_next_addr", bus.IF_addr, 32'h200);

        // rdy_in low freezes everything mid-request
        rdy_in = 1'b0;
        held   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.IF_rdy  = k[0];
            bus.IF_out  = 32'hDEAD0000 | 32'(k);
            flush_in    = (k == 5);
            flush_pc_in = 32'h300;
            @(negedge clk_in);
            if (bus.IF_op !== MEM_LOAD || bus.IF_addr !== 32'h200 || bus.inst_valid_out !== 1'b0)
                held = 1'b0;
        end
        bus.IF_rdy = 1'b0;
        flush_in   = 1'b0;
        rdy_in     = 1'b1;
        check("t5_frozen", {31'd0, held}, 32'd1);
        serve("t5_resume", 2, 32'h200);
        check("t5_hpc",   bus.inst_pc_out, 32'h200);
        check("t5_hdata", bus.inst_out, word_at(32'h200));
        wait_load("t5_next");
        check("t5_next_addr", bus.IF_addr, 32'h204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of MEM_Control.
- Holds the PC and issues word loads on the IF_* port of the memory controller.
- Buffers returned instructions, with their PCs, in a small FIFO toward decode using a valid/ready handshake.
- Supports branch redirect (flush), including discard of a load already in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0, PC loaded at reset.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- IF_op  output  2  memory op to controller (MEM_NOP / MEM_LOAD)
- IF_len  output  2  access length, always MEM_WORD
- IF_addr  output  32  fetch address
- IF_rdy  input  1  controller done; data valid on IF_out
- IF_out  input  32  fetched word
- flush_in  input  1  redirect request from execute
- flush_pc_in  input  32  redirect target
- inst_valid_out  output  1  FIFO head valid
- inst_out  output  32  head instruction
- inst_pc_out  output  32  head PC
- inst_ready_in  input  1  decode accepts head

Behaviour:
- Reset values (rst_in low, asynchronous):
  - pc=RESET_PC, state=IDLE, FIFO empty.
  - IF_op=MEM_NOP, IF_len=MEM_WORD, IF_addr=0.
  - inst_valid_out=0, inst_out=0, inst_pc_out=0.
- rdy_in low: no register changes and outputs held; IF_rdy and flush_in are ignored that cycle.
- States: IDLE, REQ, DRAIN.
- IDLE:
  - Issue when count+0 < DEPTH and no flush: IF_op<=MEM_LOAD, IF_addr<=pc, go REQ.
  - Otherwise stay in IDLE with IF_op=MEM_NOP.
- REQ:
  - IF_op and IF_addr are held stable until IF_rdy is sampled high.
  - On IF_rdy: push {IF_out, IF_addr}, pc<=pc+4, IF_op<=MEM_NOP, go IDLE.
  - A new request is issued no earlier than one cycle after IF_rdy; NOP is held at least one cycle.
- DRAIN:
  - Entered from REQ on flush_in without IF_rdy in the same cycle.
  - IF_op stays MEM_LOAD until IF_rdy; the returned word is discarded; then go IDLE.
- Flush behaviour:
  - flush_in in any state: FIFO cleared, pc<=flush_pc_in.
  - Flush in the same cycle as IF_rdy: the word is discarded, go IDLE, no DRAIN.
  - Flush in the same cycle as a dequeue: flush wins; the FIFO is empty next cycle.
- Full condition: no request is issued when count==DEPTH, so the in-flight request plus occupancy never exceeds DEPTH.
- Simultaneous push and pop when full: cannot occur (no in-flight request when full).
- Simultaneous push and pop when not full: count unchanged.
- Latency: word pushed in the IF_rdy cycle → inst_valid_out high the next cycle. No bypass.
- Dequeue: occurs when inst_valid_out && inst_ready_in; head advances next cycle.
- Arithmetic widths: pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits; pc increments modulo 2^32.

Optional Feature:
- Macro: FETCH_JAL_PREDICT_EN.
- Defined:
  - On push, if IF_out[6:0]==7'b1101111 (JAL), next pc <= IF_addr + sign-extended J-immediate {IF_out[31],IF_out[19:12],IF_out[20],IF_out[30:21],1'b0} instead of +4.
  - flush_in still overrides.
- Undefined: pc always +4; no opcode decode logic is present.

Decomposition:
- Shared defines header, consumed by this block and MEM_Control:
  - MEM_NOP=2'b00, MEM_LOAD=2'b01, MEM_SAVE=2'b10.
  - MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - ZeroWord=32'h0.
  - Fetch state encodings.
- Sub-module if_inst_fifo (DEPTH×64-bit, push/pop/clear, count, full/empty).
- Fetch FSM and pc stay in the top level.

Test Plan:
- Reset release with inst_ready_in=1 and IF_rdy returning after 5 cycles → loads at 0x0, 0x4, 0x8 in order; inst_pc_out matches each address; IF_op drops to NOP ≥1 cycle between requests.
- inst_ready_in=0 → after exactly 4 pushes, IF_op stays MEM_NOP; one pop → one new request issued.
- flush_in (flush_pc_in=0x100) during REQ at 0x8, IF_rdy 3 cycles later → that word is not enqueued; next request address is 0x100; FIFO empty in between.
- flush_in in the same cycle as IF_rdy and a dequeue → nothing enqueued; count=0 next cycle; next IF_addr=flush_pc_in; no DRAIN entered.
- rdy_in low for 10 cycles mid-REQ with IF_rdy pulsing → no state, pc or FIFO change; resumes identically after rdy_in returns high.
- FETCH_JAL_PREDICT_EN, word at 0x0 = 0x0100006F (JAL +16) → next IF_addr=0x10. Macro undefined → next IF_addr=0x4.
